// File: rtl/cmp3_pkg.sv
// Shared types and sizing constants for the 3-bit comparator sweep checker.
package cmp3_pkg;

    localparam int CMP_W = 3;
    localparam int PAIRS = 64;
    localparam int IDX_W = 6;
    localparam int ERR_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cmp3_expect.sv
// Arithmetic truth for an unsigned 3-bit compare, packed as {G, E, L}.
module cmp3_expect
    import cmp3_pkg::*;
(
    input  logic [CMP_W-1:0] i_a,
    input  logic [CMP_W-1:0] i_b,
    output logic [2:0]       o_gel
);

    assign o_gel = {(i_a > i_b), (i_a == i_b), (i_a < i_b)};

endmodule

// File: rtl/cmp3_sweep_checker.sv
// Drives all 64 operand pairs onto a 3-bit comparator, checks G/E/L after a
// settle time, and reports the error count and first failing pair.
//
//  state | meaning
//  IDLE  | results held, waiting for start
//  DRIVE | operands from idx on a*/b*, settle counter running, sample at SETTLE
//  DONE  | one-cycle done pulse, pass valid
module cmp3_sweep_checker
    import cmp3_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             a0,
    output logic             a1,
    output logic             a2,
    output logic             b0,
    output logic             b1,
    output logic             b2,
    input  logic             G,
    input  logic             E,
    input  logic             L,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [CMP_W-1:0] fail_a,
    output logic [CMP_W-1:0] fail_b
);

    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PAIRS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_cnt;
    logic [ERR_W-1:0]   r_err;
    logic [ERR_W-1:0]   w_err_next;
    logic               r_fail_valid;
    logic [CMP_W-1:0]   r_fail_a;
    logic [CMP_W-1:0]   r_fail_b;
    logic               r_pass;
    logic [2:0]         w_exp;
    logic               w_sample;
    logic               w_mismatch;
    logic               w_last;

    cmp3_expect u_expect (
        .i_a   (r_idx[5:3]),
        .i_b   (r_idx[2:0]),
        .o_gel (w_exp)
    );

    // abort wins over a coincident sample: an aborted pair is never scored
    assign w_sample   = (r_state == DRIVE) && !abort && (r_cnt == SETTLE_CNT);
    assign w_mismatch = ({G, E, L} != w_exp);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_err_next = r_err + ERR_W'(w_sample && w_mismatch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_sample && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_pass       <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_idx        <= '0;
                r_cnt        <= '0;
                r_err        <= '0;
                r_fail_valid <= 1'b0;
                r_fail_a     <= '0;
                r_fail_b     <= '0;
                r_pass       <= 1'b0;
            end
        end else if (r_state == DRIVE && !abort) begin
            if (w_sample) begin
                r_cnt <= '0;
                r_err <= w_err_next;
                if (w_mismatch && !r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_a     <= r_idx[5:3];
                    r_fail_b     <= r_idx[2:0];
                end
                // pass is settled on the final sample edge so it is valid alongside done
                if (w_last) begin
                    r_pass <= (w_err_next == '0);
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign {a2, a1, a0} = r_idx[5:3];
    assign {b2, b1, b0} = r_idx[2:0];
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign pass         = r_pass;
    assign err_count    = r_err;
    assign fail_valid   = r_fail_valid;
    assign fail_a       = r_fail_a;
    assign fail_b       = r_fail_b;

endmodule

// File: tb/tb_cmp3_sweep_checker.sv
// Scoreboard bench: stimulus queues expected sweep results, monitors compare on done.
module tb_cmp3_sweep_checker;
    import cmp3_pkg::*;

    typedef struct {
        int cyc;
        int err;
        int ps;
        int fv;
        int fa;
        int fb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start1, abort1, start3, abort3;
    logic g1, e1, l1, g3, e3, l3;
    wire [2:0] da1, db1, da3, db3;
    logic busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [6:0] err1, err3;
    logic [2:0] fa1, fb1, fa3, fb3;

    int ncyc = 0;
    int checks = 0;
    int errors = 0;
    int m1 = 0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t e1m, e3m;

    always @(negedge clk) ncyc <= ncyc + 1;

    cmp3_sweep_checker #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .a0(da1[0]), .a1(da1[1]), .a2(da1[2]),
        .b0(db1[0]), .b1(db1[1]), .b2(db1[2]),
        .G(g1), .E(e1), .L(l1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
    );

    cmp3_sweep_checker #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .a0(da3[0]), .a1(da3[1]), .a2(da3[2]),
        .b0(db3[0]), .b1(db3[1]), .b2(db3[2]),
        .G(g3), .E(e3), .L(l3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
    );

    logic [2:0] ex_a, ex_b, ex_gel;
    cmp3_expect u_exp (.i_a(ex_a), .i_b(ex_b), .o_gel(ex_gel));

    // comparator model for dut1: 0 ideal, 1 two planted faults, 2 stuck all-zero
    always_comb begin
        {g1, e1, l1} = {(da1 > db1), (da1 == db1), (da1 < db1)};
        if (m1 == 1) begin
            if (da1 == 3'd1 && db1 == 3'd1) {g1, e1, l1} = 3'b001;
            else if (da1 == 3'd2 && db1 == 3'd1) {g1, e1, l1} = 3'b110;
        end else if (m1 == 2) begin
            {g1, e1, l1} = 3'b000;
        end
    end

    // ideal comparator for dut3 whose flags lag the operands by three cycles
    logic [5:0] d1, d2, d3;
    always @(posedge clk) begin
        d1 <= {da3, db3};
        d2 <= d1;
        d3 <= d2;
    end
    always_comb begin
        {g3, e3, l3} = {(d3[5:3] > d3[2:0]), (d3[5:3] == d3[2:0]), (d3[5:3] < d3[2:0])};
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 1, 0);
            end else begin
                e1m = q1.pop_front();
                check("dut1_done_cycle", ncyc, e1m.cyc);
                check("dut1_err_count", int'(err1), e1m.err);
                check("dut1_pass", int'(pass1), e1m.ps);
                check("dut1_fail_valid", int'(fv1), e1m.fv);
                check("dut1_fail_a", int'(fa1), e1m.fa);
                check("dut1_fail_b", int'(fb1), e1m.fb);
                check("dut1_busy_at_done", int'(busy1), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (done3) begin
            if (q3.size() == 0) begin
                check("dut3_unexpected_done", 1, 0);
            end else begin
                e3m = q3.pop_front();
                check("dut3_done_cycle", ncyc, e3m.cyc);
                check("dut3_err_count", int'(err3), e3m.err);
                check("dut3_pass", int'(pass3), e3m.ps);
                check("dut3_fail_valid", int'(fv3), e3m.fv);
            end
        end
    end

    task automatic run1(input int mode, input bit push, input int err, input int ps,
                        input int fv, input int fa, input int fb);
        exp_t t;
        @(negedge clk);
        m1 = mode;
        start1 = 1'b1;
        t.cyc = ncyc + 129;
        t.err = err;
        t.ps  = ps;
        t.fv  = fv;
        t.fa  = fa;
        t.fb  = fb;
        if (push) q1.push_back(t);
        @(negedge clk);
        start1 = 1'b0;
        check("busy_after_start", int'(busy1), 1);
        check("opnd_after_start", int'({da1, db1}), 0);
    endtask

    task automatic wait_q1(input int budget);
        int k = 0;
        while (q1.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("dut1_done_timeout", q1.size(), 0);
    endtask

    task automatic wait_q3(input int budget);
        int k = 0;
        while (q3.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("dut3_done_timeout", q3.size(), 0);
    endtask

    initial begin
        exp_t t3;
        rst = 1'b1;
        start1 = 1'b0; abort1 = 1'b0;
        start3 = 1'b0; abort3 = 1'b0;
        ex_a = 3'd3; ex_b = 3'd5;
        #1 check("expect_3_5", int'(ex_gel), 3'b001);
        ex_a = 3'd5; ex_b = 3'd3;
        #1 check("expect_5_3", int'(ex_gel), 3'b100);
        ex_a = 3'd4; ex_b = 3'd4;
        #1 check("expect_4_4", int'(ex_gel), 3'b010);
        ex_a = 3'd0; ex_b = 3'd7;
        #1 check("expect_0_7", int'(ex_gel), 3'b001);

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_pass", int'(pass1), 0);
        check("rst_err", int'(err1), 0);
        check("rst_fv", int'(fv1), 0);
        check("rst_fail_ab", int'({fa1, fb1}), 0);
        check("rst_opnd", int'({da1, db1}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ideal comparator
        run1(0, 1'b1, 0, 1, 0, 0, 0);
        wait_q1(200);
        repeat (3) @(negedge clk);
        check("hold_pass", int'(pass1), 1);
        check("hold_busy", int'(busy1), 0);

        // faulted at (1,1) and (2,1)
        run1(1, 1'b1, 2, 0, 1, 1, 1);
        wait_q1(200);

        // stuck all-zero flags
        run1(2, 1'b1, 64, 0, 1, 0, 0);
        wait_q1(200);

        // abort at pair 10 with the faulted comparator
        run1(1, 1'b0, 0, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        check("abort_opnd_pair10", int'({da1, db1}), 10);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("abort_busy", int'(busy1), 0);
        check("abort_err", int'(err1), 1);
        check("abort_fv", int'(fv1), 1);
        check("abort_fail_a", int'(fa1), 1);
        check("abort_fail_b", int'(fb1), 1);
        check("abort_pass", int'(pass1), 0);
        repeat (5) @(negedge clk);
        run1(1, 1'b1, 2, 0, 1, 1, 1);
        wait_q1(200);

        // start while busy, then async reset at pair 40
        run1(2, 1'b0, 0, 0, 0, 0, 0);
        repeat (40) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("busy_start_opnd20", int'({da1, db1}), 20);
        @(negedge clk);
        check("busy_start_opnd21", int'({da1, db1}), 21);
        repeat (38) @(negedge clk);
        check("pair40_opnd", int'({da1, db1}), 40);
        check("pair40_err", int'(err1), 40);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy1), 0);
        check("arst_err", int'(err1), 0);
        check("arst_fv", int'(fv1), 0);
        check("arst_fail_ab", int'({fa1, fb1}), 0);
        check("arst_opnd", int'({da1, db1}), 0);
        check("arst_done_pass", int'({done1, pass1}), 0);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_arst_busy", int'(busy1), 0);

        // SETTLE=3 with 3-cycle flag latency
        @(negedge clk);
        start3 = 1'b1;
        t3.cyc = ncyc + 257;
        t3.err = 0; t3.ps = 1; t3.fv = 0; t3.fa = 0; t3.fb = 0;
        q3.push_back(t3);
        @(negedge clk);
        start3 = 1'b0;
        check("dut3_busy_after_start", int'(busy3), 1);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("dut3_hold_pair5", int'({da3, db3}), 5);
            @(negedge clk);
        end
        check("dut3_pair6", int'({da3, db3}), 6);
        wait_q3(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
